// File: rtl/mux4_to_1_if.sv
// Operand-select bus for mux4_to_1: one vector operand, three scalar operands,
// a 2-bit source select and the registered 192-bit result.
//   master : drives A, B, C, D, sel; observes E
//   slave  : consumes A, B, C, D, sel; drives E
interface mux4_to_1_if #(
    parameter int unsigned LANES = 6,
    parameter int unsigned WORD  = 32
);
    localparam int unsigned VEC_W = LANES * WORD;

    logic [VEC_W-1:0] A;    // vector operand, lane 0 in the LSBs
    logic [WORD-1:0]  B;    // scalar operand 1
    logic [WORD-1:0]  C;    // scalar operand 2
    logic [WORD-1:0]  D;    // scalar operand 3
    logic [1:0]       sel;  // source select
    logic [VEC_W-1:0] E;    // registered selected/broadcast result

    modport master (
        output A, B, C, D, sel,
        input  E
    );

    modport slave (
        input  A, B, C, D, sel,
        output E
    );
endinterface

// File: rtl/mux4_to_1.sv
// Registered 4-to-1 operand multiplexer for the vector datapath.
// sel=00 passes the vector operand A through; sel=01/10/11 broadcast scalar
// B/C/D into every lane. The result is registered (1-cycle latency, one result
// per cycle) and cleared by a synchronous active-low reset.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mux4_to_1_if.slave (A, B, C, D, sel in; E out)
module mux4_to_1 #(
    parameter int unsigned LANES = 6,
    parameter int unsigned WORD  = 32
) (
    input logic        clk,
    input logic        rst,
    mux4_to_1_if.slave bus
);
    localparam int unsigned VEC_W = LANES * WORD;

    logic [VEC_W-1:0] e_d;
    logic [VEC_W-1:0] e_q;

    // Source decode; every sel code is defined, scalars replicate lane-wise.
    always_comb begin
        e_d = bus.A;
        case (bus.sel)
            2'b00: e_d = bus.A;
            2'b01: e_d = {LANES{bus.B}};
            2'b10: e_d = {LANES{bus.C}};
            2'b11: e_d = {LANES{bus.D}};
        endcase
    end

    // Result register; reset takes priority over any select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign bus.E = e_q;
endmodule

// File: tb/tb_mux4_to_1.sv
module tb_mux4_to_1;
    localparam int unsigned LANES = 6;
    localparam int unsigned WORD  = 32;
    localparam int unsigned VEC_W = LANES * WORD;

    typedef struct {
        string            name;
        logic             r;
        logic [1:0]       s;
        logic [VEC_W-1:0] a;
        logic [WORD-1:0]  b;
        logic [WORD-1:0]  c;
        logic [WORD-1:0]  d;
        logic [VEC_W-1:0] e;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [VEC_W-1:0] exp_q[$];

    mux4_to_1_if #(.LANES(LANES), .WORD(WORD)) bus ();

    mux4_to_1 #(.LANES(LANES), .WORD(WORD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: build the result lane by lane.
    function automatic logic [VEC_W-1:0] model(input logic r, input logic [1:0] s,
                                               input logic [VEC_W-1:0] a,
                                               input logic [WORD-1:0] b,
                                               input logic [WORD-1:0] c,
                                               input logic [WORD-1:0] d);
        logic [VEC_W-1:0] m;
        m = '0;
        if (r) begin
            for (int i = 0; i < int'(LANES); i++) begin
                case (s)
                    2'b00: m[i*WORD +: WORD] = a[i*WORD +: WORD];
                    2'b01: m[i*WORD +: WORD] = b;
                    2'b10: m[i*WORD +: WORD] = c;
                    default: m[i*WORD +: WORD] = d;
                endcase
            end
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [VEC_W-1:0] got,
                         input logic [VEC_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Pop the oldest expected result and compare against E.
    task automatic score(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=%h", name, bus.E);
        end else begin
            check(name, bus.E, exp_q.pop_front());
        end
    endtask

    // Drive one cycle at the falling edge, push its expectation, check after the rising edge.
    task automatic step(input string name, input logic r, input logic [1:0] s,
                        input logic [VEC_W-1:0] a, input logic [WORD-1:0] b,
                        input logic [WORD-1:0] c, input logic [WORD-1:0] d,
                        input logic [VEC_W-1:0] e);
        @(negedge clk);
        rst     = r;
        bus.sel = s;
        bus.A   = a;
        bus.B   = b;
        bus.C   = c;
        bus.D   = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        score(name);
    endtask

    vec_t vecs[8];

    initial begin
        logic [VEC_W-1:0] av;
        logic [VEC_W-1:0] a2;
        logic [WORD-1:0]  bv, cv, dv;
        logic [1:0]       sv;

        total = 0;
        bad   = 0;
        av = {LANES{32'hBC7E0F03}};
        bv = 32'h80000001;
        cv = 32'h80000002;
        dv = 32'h80000000;

        rst     = 1'b0;
        bus.sel = 2'b00;
        bus.A   = '0;
        bus.B   = '0;
        bus.C   = '0;
        bus.D   = '0;

        vecs[0] = '{"reset0", 1'b0, 2'b01, av, bv, cv, dv, '0};
        vecs[1] = '{"reset1", 1'b0, 2'b11, av, bv, cv, dv, '0};
        vecs[2] = '{"pass_a", 1'b1, 2'b00, av, bv, cv, dv, {LANES{32'hBC7E0F03}}};
        vecs[3] = '{"bcast_b", 1'b1, 2'b01, av, bv, cv, dv, {LANES{32'h80000001}}};
        vecs[4] = '{"bcast_c", 1'b1, 2'b10, av, bv, cv, dv, {LANES{32'h80000002}}};
        vecs[5] = '{"bcast_d", 1'b1, 2'b11, av, bv, cv, dv, {LANES{32'h80000000}}};
        vecs[6] = '{"pass_lanes", 1'b1, 2'b00,
                    192'h66666666_55555555_44444444_33333333_22222222_11111111,
                    bv, cv, dv,
                    192'h66666666_55555555_44444444_33333333_22222222_11111111};
        vecs[7] = '{"reset_sel_change", 1'b0, 2'b10, av, bv, cv, dv, '0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].name, vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b,
                 vecs[i].c, vecs[i].d, vecs[i].e);
        end

        // Randomised back-to-back selections against the lane model.
        for (int i = 0; i < 12; i++) begin
            sv = 2'($urandom_range(0, 3));
            for (int l = 0; l < int'(LANES); l++) av[l*WORD +: WORD] = $urandom;
            bv = $urandom;
            cv = $urandom;
            dv = $urandom;
            step("random", 1'b1, sv, av, bv, cv, dv, model(1'b1, sv, av, bv, cv, dv));
        end

        av = {LANES{32'hBC7E0F03}};
        bv = 32'h80000001;
        cv = 32'h80000002;
        dv = 32'h80000000;

        // Mid-stream reset while broadcasting B.
        step("stream_b", 1'b1, 2'b01, av, bv, cv, dv, {LANES{32'h80000001}});
        step("midreset", 1'b0, 2'b01, av, bv, cv, dv, '0);
        step("after_reset", 1'b1, 2'b01, av, bv, cv, dv, {LANES{32'h80000001}});

        // Select change between edges must not reach E before the next edge.
        step("hold_a", 1'b1, 2'b00, av, bv, cv, dv, {LANES{32'hBC7E0F03}});
        @(negedge clk);
        bus.sel = 2'b01;
        #1;
        check("hold_midcycle", bus.E, {LANES{32'hBC7E0F03}});
        exp_q.push_back({LANES{32'h80000001}});
        @(posedge clk);
        #1;
        score("hold_then_b");

        // Several input glitches inside one cycle: only the settled value is captured.
        a2 = 192'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        bus.sel = 2'b00;
        bus.A   = '1;
        #1 bus.sel = 2'b11;
        #1 bus.A   = a2;
        #1 bus.sel = 2'b00;
        exp_q.push_back(a2);
        @(posedge clk);
        #1;
        score("glitch_settle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux4_to_1.md
# mux4_to_1

Registered 4-to-1 operand multiplexer for the vector datapath. It selects either a full 192-bit vector operand (six 32-bit lanes) or one of three 32-bit scalar operands. A selected scalar is broadcast to all six lanes. The result is registered and drives a 192-bit vector operand bus toward the vector ALU/writeback stage.

## Interface
- Parameters:
  - LANES, 6, number of 32-bit lanes in the vector bus
  - WORD, 32, lane and scalar width in bits
- Ports (one clock; reset is synchronous and active-low):
  - clk  input  1  rising-edge clock, sole clock
  - rst  input  1  synchronous active-low reset, sampled on clk rising edge
  - A  input  LANES*WORD (192)  vector operand; lane i = A[32*i+31 : 32*i]
  - B  input  WORD (32)  scalar operand 1
  - C  input  WORD (32)  scalar operand 2
  - D  input  WORD (32)  scalar operand 3
  - sel  input  2  source select
  - E  output  LANES*WORD (192)  registered selected/broadcast result

## Operation
- Select decode, computed combinationally and then captured in the E register:
  - sel=2'b00 -> E_next = A, passed through bit-exact
  - sel=2'b01 -> E_next = {LANES{B}}
  - sel=2'b10 -> E_next = {LANES{C}}
  - sel=2'b11 -> E_next = {LANES{D}}
- Broadcast places the scalar in every lane; lane 0 occupies the LSBs.
- All four sel codes are defined. There is no illegal code and no default-to-X.
- No arithmetic, sign extension or lane reordering. Data is transferred bitwise.
- No handshake. A new selection may be applied every cycle.

## Timing
- E updates only on the clk rising edge.
- Latency: exactly 1 cycle from sel/A/B/C/D to E. There is no combinational path from inputs to E.
- Reset: if rst==0 at a rising edge, E <= 192'h0 regardless of sel or data.
  - Reset overrides any simultaneous select change.
  - The first valid output appears at the first rising edge with rst==1.
- Reset asserted mid-stream clears E at that edge; the previously selected data is discarded.
- Inputs changing between edges have no effect on E until the next edge. Glitches are never visible on E.
- Throughput: one result per cycle. Back-to-back sel changes produce back-to-back distinct outputs with no bubble.

## Test plan
- Reset:
  - Stimulus: rst=0 for 2 edges, any sel/data.
  - Required: E==192'h0 after the first edge. E stays 0 while rst=0.
- Vector pass-through:
  - Stimulus: rst=1, A={6{32'hBC7E0F03}}, B=32'h80000001, C=32'h80000002, D=32'h80000000, sel=00.
  - Required: one edge later E=={6{32'hBC7E0F03}}.
- Scalar B broadcast:
  - Stimulus: same data, sel=01.
  - Required: next edge E=={6{32'h80000001}}.
- Scalar C and D broadcast:
  - Stimulus: sel=10, then sel=11 on consecutive cycles.
  - Required: E=={6{32'h80000002}}, then E=={6{32'h80000000}}, each exactly 1 cycle after its sel. No intermediate values.
- Latency and hold:
  - Stimulus: change sel 00->01 midway between edges.
  - Required: E keeps the A value until the next rising edge, then becomes {6{B}}.
- Reset mid-stream:
  - Stimulus: with sel=01 streaming, drop rst=0 for one edge, then release.
  - Required: E==0 for that cycle, then {6{32'h80000001}} on the following edge.
